// File: rtl/fpu_float_to_int_if.sv
// Request/response bundle of the float-to-int converter.
// The requester drives start/num/is_signed and receives the converted result.
interface fpu_float_to_int_if;
    logic        start;
    logic [31:0] num;
    logic        is_signed;
    logic        busy;
    logic        valid;
    logic [31:0] result;
    logic        invalid;
    logic        inexact;

    modport master (
        output start, num, is_signed,
        input  busy, valid, result, invalid, inexact
    );

    modport slave (
        input  start, num, is_signed,
        output busy, valid, result, invalid, inexact
    );
endinterface

// File: rtl/fpu_float_to_int.sv
// IEEE-754 single to int32/uint32 converter: unpack, bit-serial align,
// round (truncate or RNE), saturate, with invalid/inexact flags.
module fpu_float_to_int #(
    parameter bit ROUND_MODE = 1'b1
) (
    input logic           clk,
    input logic           rstn,
    fpu_float_to_int_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, UNPACK, SHIFT, ROUND, DONE
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] num_q, num_d;
    logic        sgn_q, sgn_d;
    logic [55:0] w_q, w_d;
    logic        g_q, g_d;
    logic        r_q, r_d;
    logic        s_q, s_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        left_q, left_d;
    logic [31:0] pres_q, pres_d;
    logic        pinv_q, pinv_d;
    logic        pinx_q, pinx_d;
    logic [31:0] result_q, result_d;
    logic        invalid_q, invalid_d;
    logic        inexact_q, inexact_d;
    logic        valid_q, valid_d;

    logic        sign;
    logic [7:0]  exp_v;
    logic [22:0] frac;
    logic        nan;
    logic        is_spec;
    logic        is_zero;
    logic        is_under;
    logic        is_over;
    logic        is_left;
    logic [7:0]  shamt;
    logic [31:0] mag;
    logic        inc;
    logic [31:0] magr;

    assign sign     = num_q[31];
    assign exp_v    = num_q[30:23];
    assign frac     = num_q[22:0];
    assign nan      = (frac != 23'd0);
    assign is_spec  = (exp_v == 8'hFF);
    assign is_zero  = (exp_v == 8'h00);
    assign is_under = !is_zero && (exp_v < 8'd126);
    // -2^31 is the only signed operand with e=31 that still fits
    assign is_over  = !is_spec && (sgn_q
                    ? (exp_v >= 8'd158 && num_q != 32'hCF00_0000)
                    : (exp_v >= 8'd159));
    assign is_left  = (exp_v >= 8'd150);
    assign shamt    = is_left ? (exp_v - 8'd150) : (8'd150 - exp_v);

    assign mag  = w_q[31:0];
    assign inc  = ROUND_MODE && g_q && (r_q || s_q || mag[0]);
    assign magr = mag + {31'd0, inc};

    function automatic logic [31:0] sat(input logic is_sgn, input logic neg);
        if (is_sgn) return neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return neg ? 32'h0000_0000 : 32'hFFFF_FFFF;
    endfunction

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        sgn_d     = sgn_q;
        w_d       = w_q;
        g_d       = g_q;
        r_d       = r_q;
        s_d       = s_q;
        cnt_d     = cnt_q;
        left_d    = left_q;
        pres_d    = pres_q;
        pinv_d    = pinv_q;
        pinx_d    = pinx_q;
        result_d  = result_q;
        invalid_d = invalid_q;
        inexact_d = inexact_q;
        valid_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    num_d   = bus.num;
                    sgn_d   = bus.is_signed;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                w_d    = {32'd0, 1'b1, frac};
                g_d    = 1'b0;
                r_d    = 1'b0;
                s_d    = 1'b0;
                pres_d = 32'd0;
                pinv_d = 1'b0;
                pinx_d = 1'b0;
                unique case (1'b1)
                    is_spec: begin
                        pinv_d  = 1'b1;
                        pres_d  = sat(sgn_q, sign && !nan);
                        state_d = DONE;
                    end
                    is_zero: begin
                        pinx_d  = nan;
                        state_d = DONE;
                    end
                    is_under: begin
                        pinx_d  = 1'b1;
                        state_d = DONE;
                    end
                    is_over: begin
                        pinv_d  = 1'b1;
                        pres_d  = sat(sgn_q, sign);
                        state_d = DONE;
                    end
                    default: begin
                        left_d  = is_left;
                        cnt_d   = shamt;
                        state_d = (shamt == 8'd0) ? ROUND : SHIFT;
                    end
                endcase
            end
            SHIFT: begin
                if (left_q) begin
                    w_d = w_q << 1;
                end else begin
                    w_d = w_q >> 1;
                    g_d = w_q[0];
                    r_d = g_q;
                    s_d = s_q | r_q;
                end
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) state_d = ROUND;
            end
            ROUND: begin
                // a negative value that survives rounding has no uint32 form
                if (!sgn_q && sign && magr != 32'd0) begin
                    pinv_d = 1'b1;
                    pinx_d = 1'b0;
                    pres_d = 32'd0;
                end else begin
                    pinv_d = 1'b0;
                    pinx_d = g_q | r_q | s_q;
                    pres_d = sign ? (~magr + 32'd1) : magr;
                end
                state_d = DONE;
            end
            DONE: begin
                result_d  = pres_q;
                invalid_d = pinv_q;
                inexact_d = pinx_q;
                valid_d   = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            num_q     <= 32'd0;
            sgn_q     <= 1'b0;
            w_q       <= 56'd0;
            g_q       <= 1'b0;
            r_q       <= 1'b0;
            s_q       <= 1'b0;
            cnt_q     <= 8'd0;
            left_q    <= 1'b0;
            pres_q    <= 32'd0;
            pinv_q    <= 1'b0;
            pinx_q    <= 1'b0;
            result_q  <= 32'd0;
            invalid_q <= 1'b0;
            inexact_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            sgn_q     <= sgn_d;
            w_q       <= w_d;
            g_q       <= g_d;
            r_q       <= r_d;
            s_q       <= s_d;
            cnt_q     <= cnt_d;
            left_q    <= left_d;
            pres_q    <= pres_d;
            pinv_q    <= pinv_d;
            pinx_q    <= pinx_d;
            result_q  <= result_d;
            invalid_q <= invalid_d;
            inexact_q <= inexact_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.valid   = valid_q;
    assign bus.result  = result_q;
    assign bus.invalid = invalid_q;
    assign bus.inexact = inexact_q;

endmodule
